si_reply_frame: RTL and testbench

- Sits directly downstream of the SI section extractor. Consumes its byte-wide reply stream: per UDP segment, an 8-byte header (04 01 00 00 00 seg 00 total) plus section bytes, or a 12-byte null reply.
- Delimits frames, buffers them in a byte RAM with a length queue, and hands complete frames to the host-side UDP sender through a req/ack handshake.
- Isolates the extractor, which cannot be back-pressured, from a shared sender that may be busy.

---
 rtl/si_reply_frame.sv | 189 ++++++++++++++++++
 tb/tb_si_reply_frame.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si_reply_frame.sv
// Buffers extractor reply frames in a byte RAM + length queue and offers them to the UDP sender by req/ack.
// Latency: first reply byte 2 cycles after ack; input is never stalled, frames are dropped when queue/buffer cannot take them.
module si_reply_frame #(
   parameter int ADDR_W  = 12,
   parameter int LQ_AW   = 2,
   parameter int MIN_LEN = 8,
   parameter int MAX_LEN = 1464
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  si_din,
   input  logic        si_din_en,
   output logic        reply_req,
   output logic [11:0] reply_len,
   input  logic        reply_ack,
   output logic [7:0]  reply_dout,
   output logic        reply_dout_en,
   output logic [15:0] drop_cnt
);
   localparam int OCC_W = ADDR_W + 1;
   localparam int LQ_DEPTH = 1 << LQ_AW;
   localparam logic [ADDR_W:0] BUF_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [LQ_AW:0] LQ_FULL = {1'b1, {LQ_AW{1'b0}}};
   localparam logic [11:0] MIN_L = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L = 12'(MAX_LEN);

   typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
   typedef enum logic [2:0] {R_IDLE, R_REQ, R_LEAD, R_SEND, R_GAP} r_state_t;

   w_state_t w_state;
   r_state_t r_state;

   logic [7:0]        mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] fstart;
   logic [ADDR_W-1:0] rd_ptr;
   logic [11:0]       fcnt;
   logic [11:0]       send_cnt;
   logic [ADDR_W:0]   occ;

   logic [11:0]       lq [0:LQ_DEPTH-1];
   logic [LQ_AW-1:0]  lq_wp;
   logic [LQ_AW-1:0]  lq_rp;
   logic [LQ_AW:0]    lq_cnt;

   logic buf_full, lq_full, start_ok, wr_frame, abort, end_ok, end_bad;
   logic mem_we, rd_fire, lq_push, lq_pop, drop_inc, rollback;

   always_comb begin
      buf_full = (occ == BUF_FULL);
      lq_full  = (lq_cnt == LQ_FULL);
      start_ok = (w_state == W_IDLE) && si_din_en && !lq_full && !buf_full;
      wr_frame = (w_state == W_FRAME) && si_din_en && !buf_full && (fcnt < MAX_L);
      abort    = (w_state == W_FRAME) && si_din_en && !wr_frame;
      end_ok   = (w_state == W_FRAME) && !si_din_en && (fcnt >= MIN_L);
      end_bad  = (w_state == W_FRAME) && !si_din_en && (fcnt < MIN_L);
      rollback = abort || end_bad;
      mem_we   = start_ok || wr_frame;
      rd_fire  = (r_state == R_LEAD) || ((r_state == R_SEND) && (send_cnt != 12'd0));
      lq_push  = end_ok;
      lq_pop   = (r_state == R_GAP);
      drop_inc = end_bad || ((w_state == W_DROP) && !si_din_en);
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_ptr] <= si_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state  <= W_IDLE;
         wr_ptr   <= '0;
         fstart   <= '0;
         fcnt     <= '0;
         drop_cnt <= '0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (start_ok) begin
                  fstart  <= wr_ptr;
                  wr_ptr  <= wr_ptr + 1'b1;
                  fcnt    <= 12'd1;
                  w_state <= W_FRAME;
               end else if (si_din_en) begin
                  w_state <= W_DROP;
               end
            end
            W_FRAME: begin
               if (wr_frame) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  fcnt   <= fcnt + 12'd1;
               end else if (abort) begin
                  wr_ptr  <= fstart;
                  w_state <= W_DROP;
               end else begin
                  if (end_bad)
                     wr_ptr <= fstart;
                  w_state <= W_IDLE;
               end
            end
            W_DROP: begin
               if (!si_din_en)
                  w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
         if (drop_inc && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Occupancy covers in-flight bytes too, so an aborted frame hands its space back here.
   always_ff @(posedge clk) begin
      if (rst)
         occ <= '0;
      else
         occ <= occ + OCC_W'(mem_we) - OCC_W'(rd_fire) - (rollback ? OCC_W'(fcnt) : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lq_wp  <= '0;
         lq_rp  <= '0;
         lq_cnt <= '0;
         for (int i = 0; i < LQ_DEPTH; i++)
            lq[i] <= '0;
      end else begin
         if (lq_push) begin
            lq[lq_wp] <= fcnt;
            lq_wp     <= lq_wp + 1'b1;
         end
         if (lq_pop)
            lq_rp <= lq_rp + 1'b1;
         if (lq_push && !lq_pop)
            lq_cnt <= lq_cnt + 1'b1;
         else if (lq_pop && !lq_push)
            lq_cnt <= lq_cnt - 1'b1;
      end
   end

   // The RAM read is registered into reply_dout, so R_LEAD absorbs the read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= R_IDLE;
         reply_req     <= 1'b0;
         reply_len     <= '0;
         reply_dout    <= '0;
         reply_dout_en <= 1'b0;
         rd_ptr        <= '0;
         send_cnt      <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (lq_cnt != '0) begin
                  reply_req <= 1'b1;
                  reply_len <= lq[lq_rp];
                  r_state   <= R_REQ;
               end
            end
            R_REQ: begin
               if (reply_ack) begin
                  reply_req <= 1'b0;
                  r_state   <= R_LEAD;
               end
            end
            R_LEAD: begin
               reply_dout    <= mem[rd_ptr];
               reply_dout_en <= 1'b1;
               rd_ptr        <= rd_ptr + 1'b1;
               send_cnt      <= reply_len - 12'd1;
               r_state       <= R_SEND;
            end
            R_SEND: begin
               if (send_cnt != 12'd0) begin
                  reply_dout <= mem[rd_ptr];
                  rd_ptr     <= rd_ptr + 1'b1;
                  send_cnt   <= send_cnt - 12'd1;
               end else begin
                  reply_dout_en <= 1'b0;
                  r_state       <= R_GAP;
               end
            end
            R_GAP:   r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_si_reply_frame.sv
// Bench for si_reply_frame: directed scenarios plus randomized streaming against a byte/length scoreboard.
module tb_si_reply_frame;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  si_din = 8'd0;
   logic        si_din_en = 1'b0;
   logic        reply_req;
   logic [11:0] reply_len;
   logic        reply_ack = 1'b0;
   logic [7:0]  reply_dout;
   logic        reply_dout_en;
   logic [15:0] drop_cnt;

   si_reply_frame dut (
      .clk(clk), .rst(rst), .si_din(si_din), .si_din_en(si_din_en),
      .reply_req(reply_req), .reply_len(reply_len), .reply_ack(reply_ack),
      .reply_dout(reply_dout), .reply_dout_en(reply_dout_en), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   logic [7:0] exp_bytes[$];
   int         exp_len[$];
   logic [7:0] cur[$];
   int  exp_drop = 0;
   int  frames_pushed = 0;
   int  frames_done = 0;
   bit  auto_ack = 1'b1;
   int  ack_dly = 0;
   bit  prev_en = 1'b0;
   int  e_len;
   logic [7:0] e_byte;

   // Sender model: single-cycle ack after a short random wait.
   always @(posedge clk) begin
      #1;
      if (reply_ack)
         reply_ack = 1'b0;
      else if (auto_ack && reply_req && !rst) begin
         if (ack_dly == 0) begin
            reply_ack = 1'b1;
            ack_dly = $urandom_range(0, 3);
         end else
            ack_dly = ack_dly - 1;
      end
   end

   // Scoreboard: offered lengths and emitted bytes must follow the accepted frames in order.
   always @(negedge clk) begin
      if (rst)
         prev_en = 1'b0;
      else begin
         if (reply_req && reply_ack) begin
            n_cmp++;
            if (exp_len.size() == 0) begin
               n_fail++;
               $display("FAIL offer_len: offered len %0d, no frame expected", reply_len);
            end else begin
               e_len = exp_len.pop_front();
               if (reply_len !== e_len[11:0]) begin
                  n_fail++;
                  $display("FAIL offer_len: got %0d, expected %0d", reply_len, e_len);
               end
            end
         end
         if (reply_dout_en) begin
            n_cmp++;
            if (exp_bytes.size() == 0) begin
               n_fail++;
               $display("FAIL out_byte: byte %h emitted, none expected", reply_dout);
            end else begin
               e_byte = exp_bytes.pop_front();
               if (reply_dout !== e_byte) begin
                  n_fail++;
                  $display("FAIL out_byte: got %h, expected %h", reply_dout, e_byte);
               end
            end
         end
         if (prev_en && !reply_dout_en)
            frames_done++;
         prev_en = reply_dout_en;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic gen_frame(input int len);
      logic [7:0] hdr [8] = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
      cur.delete();
      for (int i = 0; i < len; i++)
         cur.push_back(i < 8 ? hdr[i] : 8'($urandom));
   endtask

   task automatic expect_cur();
      foreach (cur[i]) exp_bytes.push_back(cur[i]);
      exp_len.push_back(cur.size());
      frames_pushed++;
   endtask

   task automatic drive_cur();
      foreach (cur[i]) begin
         @(posedge clk); #1;
         si_din = cur[i];
         si_din_en = 1'b1;
      end
      @(posedge clk); #1;
      si_din_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_bytes.size() == 0 && exp_len.size() == 0 && !reply_req && !reply_dout_en) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (reply_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b, expected 0", reply_req); end
      n_cmp++; if (reply_len !== 12'd0) begin n_fail++; $display("FAIL rst_len: got %0d, expected 0", reply_len); end
      n_cmp++; if (reply_dout_en !== 1'b0) begin n_fail++; $display("FAIL rst_dout_en: got %b, expected 0", reply_dout_en); end
      n_cmp++; if (reply_dout !== 8'd0) begin n_fail++; $display("FAIL rst_dout: got %h, expected 00", reply_dout); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d, expected 0", drop_cnt); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      bit found, ok;
      int hi;
      gen_frame(28);
      expect_cur();
      drive_cur();
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (reply_req && reply_ack) begin found = 1'b1; break; end
      end
      n_cmp++;
      if (!found) begin
         n_fail++; $display("FAIL basic_ack: no acked request within 100 cycles, expected one");
      end else begin
         @(negedge clk);
         n_cmp++;
         if (reply_dout_en !== 1'b0 || reply_req !== 1'b0) begin
            n_fail++; $display("FAIL basic_lead: T+1 req=%b en=%b, expected 0 0", reply_req, reply_dout_en);
         end
         hi = 0;
         for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (reply_dout_en === 1'b1) hi++;
         end
         n_cmp++; if (hi !== 28) begin n_fail++; $display("FAIL basic_window: en high %0d of T+2..T+29, expected 28", hi); end
         @(negedge clk);
         n_cmp++; if (reply_dout_en !== 1'b0) begin n_fail++; $display("FAIL basic_end: en at T+30 %b, expected 0", reply_dout_en); end
      end
      wait_idle(200, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_drain: frame not fully emitted, %0d bytes left", exp_bytes.size()); end
      n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL basic_drop: got %0d, expected %0d", drop_cnt, exp_drop); end
   endtask

   task automatic test_null_short();
      bit ok;
      gen_frame(12);
      for (int i = 8; i < 12; i++) cur[i] = 8'hFF;
      expect_cur();
      drive_cur();
      wait_idle(200, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL null_drain: null reply not emitted, %0d bytes left", exp_bytes.size()); end
      gen_frame(5);
      exp_drop++;
      drive_cur();
      repeat (10) @(negedge clk);
      n_cmp++; if (reply_req !== 1'b0) begin n_fail++; $display("FAIL short_req: got %b, expected 0", reply_req); end
      n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL short_drop: got %0d, expected %0d", drop_cnt, exp_drop); end
   endtask

   task automatic test_queue_full();
      bit ok;
      int done0;
      auto_ack = 1'b0;
      for (int f = 0; f < 5; f++) begin
         gen_frame(100);
         if (f < 4) expect_cur(); else exp_drop++;
         drive_cur();
      end
      repeat (4) @(negedge clk);
      n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL qfull_drop: got %0d, expected %0d", drop_cnt, exp_drop); end
      n_cmp++; if (reply_req !== 1'b1) begin n_fail++; $display("FAIL qfull_req: got %b, expected 1", reply_req); end
      n_cmp++; if (reply_len !== 12'd100) begin n_fail++; $display("FAIL qfull_len: got %0d, expected 100", reply_len); end
      done0 = frames_done;
      auto_ack = 1'b1;
      wait_idle(2000, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL qfull_drain: %0d bytes left", exp_bytes.size()); end
      n_cmp++; if (frames_done - done0 !== 4) begin n_fail++; $display("FAIL qfull_count: %0d frames emitted, expected 4", frames_done - done0); end
   endtask

   task automatic test_oversize();
      bit ok;
      gen_frame(1500);
      exp_drop++;
      drive_cur();
      repeat (3) @(negedge clk);
      n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL over_drop: got %0d, expected %0d", drop_cnt, exp_drop); end
      n_cmp++; if (reply_req !== 1'b0) begin n_fail++; $display("FAIL over_req: got %b, expected 0", reply_req); end
      gen_frame(200);
      expect_cur();
      drive_cur();
      wait_idle(1000, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL over_next: 200-byte frame incomplete, %0d bytes left", exp_bytes.size()); end
   endtask

   task automatic test_stream();
      bit ok;
      int len, waited;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(8, 400);
         waited = 0;
         while ((frames_pushed - frames_done > 2 || exp_bytes.size() + len > 3500) && waited < 5000) begin
            @(posedge clk);
            waited++;
         end
         n_cmp++;
         if (waited >= 5000) begin
            n_fail++; $display("FAIL stream_stall: %0d frames outstanding after 5000 cycles, expected drain", frames_pushed - frames_done);
         end
         gen_frame(len);
         cur[5] = 8'(f);
         expect_cur();
         drive_cur();
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle(5000, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL stream_drain: %0d bytes left", exp_bytes.size()); end
      n_cmp++; if (drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL stream_drop: got %0d, expected %0d", drop_cnt, exp_drop); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      gen_frame(50);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         si_din = cur[i];
         si_din_en = 1'b1;
      end
      @(posedge clk); #1;
      rst = 1'b1;
      si_din_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_drop = 0;
      @(negedge clk);
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_drop: got %0d, expected 0", drop_cnt); end
      n_cmp++; if (reply_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %b, expected 0", reply_req); end
      gen_frame(30);
      expect_cur();
      drive_cur();
      wait_idle(500, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_drain: 30-byte frame incomplete, %0d bytes left", exp_bytes.size()); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_drop_end: got %0d, expected 0", drop_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_null_short();
      test_queue_full();
      test_oversize();
      test_stream();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
